// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Purpose  : APB state encoding, response codes and index-width helpers.
// Revision : 1.0
// ============================================================================
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } apb_state_e;

   localparam logic APB_OKAY = 1'b0;
   localparam logic APB_ERR  = 1'b1;

   function automatic int apb_alsb(input int dwidth);
      return $clog2(dwidth / 8);
   endfunction

   function automatic int apb_idxw(input int depth);
      return $clog2(depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_regfile_mem.sv
`default_nettype none
// ============================================================================
// Module   : apb_regfile_mem
// Purpose  : DEPTH x DWIDTH register array, one write port, registered read.
// Revision : 1.0
// ============================================================================
module apb_regfile_mem
   import apb_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 16,
   parameter int IDXW   = apb_idxw(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [IDXW-1:0]   i_waddr,
   input  logic [DWIDTH-1:0] i_wdata,
   input  logic              i_re,
   input  logic [IDXW-1:0]   i_raddr,
   output logic [DWIDTH-1:0] o_rdata
);

   logic [DWIDTH-1:0] r_mem [DEPTH];
   logic [DWIDTH-1:0] r_rdata;

   // Read register returns zero whenever no read is being launched.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rdata <= '0;
      end else begin
         if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
         end
         r_rdata <= i_re ? r_mem[i_raddr] : '0;
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regfile
// Purpose  : APB completer with register file, wait states and range errors.
// Revision : 1.0
// ============================================================================
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int AWIDTH      = 32,
   parameter int DWIDTH      = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [AWIDTH-1:0] PADDR,
   input  logic [DWIDTH-1:0] PWDATA,
   output logic [DWIDTH-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR
);

   localparam int              c_ALSB     = apb_alsb(DWIDTH);
   localparam int              c_IDXW     = apb_idxw(DEPTH);
   localparam logic [AWIDTH-1:0] c_LIMIT  = AWIDTH'(DEPTH * (DWIDTH / 8));
   localparam logic [3:0]      c_CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   apb_state_e        r_state, w_next;
   logic [3:0]        r_cnt;
   logic              r_write, r_oor, r_pready, r_pslverr;
   logic [c_IDXW-1:0] r_idx;
   logic [DWIDTH-1:0] r_wdata;

   logic              w_setup, w_access, w_enter_ready, w_we, w_re;
   logic              w_cur_write, w_cur_oor;
   logic [c_IDXW-1:0] w_cur_idx;

   assign w_setup  = PSEL & ~PENABLE;
   assign w_access = PSEL & PENABLE;

   // With zero wait states READY is entered on the setup edge itself, so the
   // live bus fields are used in IDLE instead of the not-yet-captured copies.
   assign w_cur_write = (r_state == IDLE) ? PWRITE : r_write;
   assign w_cur_oor   = (r_state == IDLE) ? (PADDR >= c_LIMIT) : r_oor;
   assign w_cur_idx   = (r_state == IDLE) ? PADDR[c_ALSB +: c_IDXW] : r_idx;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_setup) w_next = (WAIT_STATES == 0) ? READY : WAIT;
         WAIT: begin
            if (!PSEL)                          w_next = IDLE;
            else if (PENABLE && r_cnt == 4'd0)  w_next = READY;
         end
         READY:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_enter_ready = (r_state != READY) && (w_next == READY);
   assign w_re = w_enter_ready & ~w_cur_write & ~w_cur_oor;
   assign w_we = (r_state == READY) & w_access & r_write & ~r_oor;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_write   <= 1'b0;
         r_oor     <= 1'b0;
         r_idx     <= '0;
         r_wdata   <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= APB_OKAY;
      end else begin
         r_state   <= w_next;
         r_pready  <= (w_next == READY);
         r_pslverr <= (w_enter_ready && w_cur_oor) ? APB_ERR : APB_OKAY;
         if (r_state == IDLE && w_setup) begin
            r_write <= PWRITE;
            r_oor   <= (PADDR >= c_LIMIT);
            r_idx   <= PADDR[c_ALSB +: c_IDXW];
            r_wdata <= PWDATA;
            r_cnt   <= c_CNT_INIT;
         end else if (r_state == WAIT && w_access && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   apb_regfile_mem #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .IDXW   (c_IDXW)
   ) u_mem (
      .clk     (PCLK),
      .rst     (PRESET),
      .i_we    (w_we),
      .i_waddr (r_idx),
      .i_wdata (r_wdata),
      .i_re    (w_re),
      .i_raddr (w_cur_idx),
      .o_rdata (PRDATA)
   );

   assign PREADY  = r_pready;
   assign PSLVERR = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_regfile
// Purpose  : Directed checks of three slaves with 1, 0 and 3 wait states.
// Revision : 1.0
// ============================================================================
module tb_apb_slave_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  psel;
   logic        penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata [3];
   logic        pready [3];
   logic        pslverr [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Index 0: one wait state, index 1: none, index 2: three.
   apb_slave_regfile #(.AWIDTH(32), .DWIDTH(32), .DEPTH(16), .WAIT_STATES(1)) u_dut_ws1 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
   apb_slave_regfile #(.AWIDTH(32), .DWIDTH(32), .DEPTH(16), .WAIT_STATES(0)) u_dut_ws0 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
   apb_slave_regfile #(.AWIDTH(32), .DWIDTH(32), .DEPTH(16), .WAIT_STATES(3)) u_dut_ws3 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

   // Full transfer; returns after the edge that closes the READY cycle so a
   // following call issues its setup back-to-back.
   task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat);
      psel    = 3'b000;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      @(posedge clk); #1;
      penable = 1'b1;
      lat = 1;
      while (pready[d] !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (pready[d] !== 1'b1) begin
         lat = -1; rdata = 'x; err = 1'bx;
      end else begin
         rdata = prdata[d]; err = pslverr[d];
      end
      @(posedge clk); #1;
   endtask

   task automatic bus_idle();
      psel = 3'b000; penable = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic er; int lat;
      rst = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         n_tests++; if (pready[d] !== 1'b0)  begin n_fail++; $display("FAIL reset_pready[%0d] got %b exp 0", d, pready[d]); end
         n_tests++; if (pslverr[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr[%0d] got %b exp 0", d, pslverr[d]); end
         n_tests++; if (prdata[d] !== 32'h0) begin n_fail++; $display("FAIL reset_prdata[%0d] got %h exp 0", d, prdata[d]); end
      end
      rst = 1'b0;
      @(posedge clk); #1;
      apb_xfer(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL reset_read0 got %h/%b exp 00000000/0", rd, er); end
      bus_idle();
   endtask

   task automatic test_wait1();
      logic [31:0] rd; logic er; int lat;
      apb_xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, rd, er, lat);
      n_tests++; if (lat !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL ws1_write lat/err got %0d/%b exp 2/0", lat, er); end
      bus_idle();
      apb_xfer(0, 1'b0, 32'h04, 32'h0, rd, er, lat);
      n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL ws1_read_lat got %0d exp 2", lat); end
      n_tests++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL ws1_read got %h/%b exp deadbeef/0", rd, er); end
      bus_idle();
      n_tests++; if (prdata[0] !== 32'h0 || pready[0] !== 1'b0) begin n_fail++; $display("FAIL ws1_after got %h/%b exp 0/0", prdata[0], pready[0]); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int lat;
      apb_xfer(1, 1'b1, 32'h08, 32'h1, rd, er, lat);
      n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL b2b_wr0_lat got %0d exp 1", lat); end
      apb_xfer(1, 1'b1, 32'h0C, 32'h2, rd, er, lat);
      n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL b2b_wr1_lat got %0d exp 1", lat); end
      apb_xfer(1, 1'b0, 32'h08, 32'h0, rd, er, lat);
      n_tests++; if (lat !== 1 || rd !== 32'h1 || er !== 1'b0) begin n_fail++; $display("FAIL b2b_rd0 got %0d/%h/%b exp 1/00000001/0", lat, rd, er); end
      apb_xfer(1, 1'b0, 32'h0C, 32'h0, rd, er, lat);
      n_tests++; if (lat !== 1 || rd !== 32'h2 || er !== 1'b0) begin n_fail++; $display("FAIL b2b_rd1 got %0d/%h/%b exp 1/00000002/0", lat, rd, er); end
      bus_idle();
   endtask

   task automatic test_out_of_range();
      logic [31:0] rd; logic er; int lat; logic [31:0] exp_v;
      apb_xfer(0, 1'b0, 32'h40, 32'h0, rd, er, lat);
      n_tests++; if (lat !== 2 || rd !== 32'h0 || er !== 1'b1) begin n_fail++; $display("FAIL oor_read got %0d/%h/%b exp 2/00000000/1", lat, rd, er); end
      bus_idle();
      n_tests++; if (pslverr[0] !== 1'b0) begin n_fail++; $display("FAIL oor_err_clear got %b exp 0", pslverr[0]); end
      apb_xfer(0, 1'b1, 32'h40, 32'hFF, rd, er, lat);
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_write_err got %b exp 1", er); end
      apb_xfer(0, 1'b0, 32'h3C, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL last_word got %h/%b exp 00000000/0", rd, er); end
      for (int i = 0; i < 16; i++) begin
         exp_v = (i == 1) ? 32'hDEADBEEF : 32'h0;
         apb_xfer(0, 1'b0, 32'(i * 4), 32'h0, rd, er, lat);
         n_tests++; if (rd !== exp_v || er !== 1'b0) begin n_fail++; $display("FAIL oor_regs[%0d] got %h/%b exp %h/0", i, rd, er, exp_v); end
      end
      bus_idle();
   endtask

   task automatic test_abort();
      logic [31:0] rd; logic er; int lat;
      apb_xfer(2, 1'b1, 32'h10, 32'h12345678, rd, er, lat);
      n_tests++; if (lat !== 4 || er !== 1'b0) begin n_fail++; $display("FAIL ws3_write got %0d/%b exp 4/0", lat, er); end
      bus_idle();
      psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h55;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int c = 0; c < 2; c++) begin
         n_tests++; if (pready[2] !== 1'b0) begin n_fail++; $display("FAIL abort_access[%0d] got %b exp 0", c, pready[2]); end
         @(posedge clk); #1;
      end
      psel = 3'b000; penable = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         n_tests++; if (pready[2] !== 1'b0) begin n_fail++; $display("FAIL abort_idle[%0d] got %b exp 0", c, pready[2]); end
      end
      apb_xfer(2, 1'b0, 32'h10, 32'h0, rd, er, lat);
      n_tests++; if (lat !== 4 || rd !== 32'h12345678 || er !== 1'b0) begin n_fail++; $display("FAIL abort_readback got %0d/%h/%b exp 4/12345678/0", lat, rd, er); end
      bus_idle();
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat;
      psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hAA;
      @(posedge clk); #1;
      penable = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_tests++; if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_out got %b/%b exp 0/0", pready[0], pslverr[0]); end
      rst = 1'b0; psel = 3'b000; penable = 1'b0;
      @(posedge clk); #1;
      apb_xfer(0, 1'b0, 32'h14, 32'h0, rd, er, lat);
      n_tests++; if (lat !== 2 || rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_reg5 got %0d/%h exp 2/00000000", lat, rd); end
      apb_xfer(0, 1'b0, 32'h04, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_reg1 got %h exp 00000000", rd); end
      bus_idle();
   endtask

   initial begin
      test_reset();
      test_wait1();
      test_back_to_back();
      test_out_of_range();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
